mem_bus_scheduler: RTL and testbench
====================================

# mem_bus_scheduler

Round-robin scheduler that shares the single common memory bus (address/read/write/mask/value/ready/fault) between several bus masters: the CPU's bus arbiter output, DMA and the video fetcher. It grants one master at a time and holds the grant until the slave answers with ready. A watchdog converts a hung slave into a fault. It sits between the masters and the memory/peripheral decoder.

## Interface
- NUM_MASTERS, 3, number of requesters (2..8)
- TIMEOUT_CYCLES, 1024, BUSY cycles before forced fault; 0 disables the watchdog
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce_i  in  1  clock enable; registers update only when high
- m_address_in  in  NUM_MASTERS×32  per-master address
- m_read_in / m_write_in  in  NUM_MASTERS×1  per-master request (level, held until ready)
- m_write_mask_in  in  NUM_MASTERS×4  byte mask
- m_write_value_in  in  NUM_MASTERS×32  write data
- m_read_value_out  out  NUM_MASTERS×32  read data; equals read_value_in for granted master, else 0
- m_ready_out / m_fault_out  out  NUM_MASTERS×1  completion / error to granted master only
- address_out, read_out, write_out, write_mask_out, write_value_out  out  32,1,1,4,32  common bus
- read_value_in, ready_in, fault_in  in  32,1,1  common bus response
- grant_idx_out  out  3  current grant index (debug)
- busy_out  out  1  high in BUSY

## Operation
- States: IDLE, BUSY.
- req[i] = m_read_in[i] | m_write_in[i].
- IDLE:
  - Common-bus outputs are all 0.
  - If any req, the picker selects the first requesting index at or after rr_ptr (wrapping), registers it into grant, clears the timeout counter and enters BUSY.
- BUSY:
  - Common bus is driven combinationally from master[grant].
  - ready_in/fault_in are routed to m_ready_out/m_fault_out[grant].
- BUSY exit conditions, priority order:
  - (a) Abort: req[grant] low → IDLE, no ready to anyone.
  - (b) ready_in → IDLE; rr_ptr = (grant+1) mod NUM_MASTERS.
  - (c) Timeout: counter == TIMEOUT_CYCLES-1 and no ready_in → that cycle m_ready_out[grant]=1, m_fault_out[grant]=1, read_out=write_out=0; → IDLE; rr_ptr advances as in (b).
- Counter increments each ce_i cycle in BUSY and saturates; width is clog2(TIMEOUT_CYCLES+1).
- Read and write both high from one master: passed through unchanged (decoder's problem).
- ce_i low: state, grant, counter and rr_ptr hold; combinational routing still follows grant.
- Reset values: state IDLE, rr_ptr 0, grant 0, counter 0. All outputs are 0, including busy_out and grant_idx_out.
- Reset mid-BUSY abandons the transaction: no ready or fault is issued, and the bus is released immediately (asynchronous).

## Timing
- Request at edge N (IDLE) → grant registered at N+1. The bus is driven during cycle N+1.
- Zero-wait slave (ready_in in the first BUSY cycle) → master sees ready in cycle N+1. The arbiter is back in IDLE at N+2.
- One mandatory IDLE cycle separates consecutive grants. Max throughput is one transaction per 2 cycles.
- Fairness: each waiting master is granted within NUM_MASTERS transactions.
- Timeout fault appears in BUSY cycle TIMEOUT_CYCLES (1-based) after grant.

## Structure
- Package mem_bus_sched_pkg holds:
  - state enum (IDLE, BUSY)
  - MAX_MASTERS = 8
  - GRANT_W = 3
  - function for counter width
- Sub-module rr_priority_picker (req vector, pointer → one-hot and index, valid); purely combinational.
- Top holds the FSM, counter and muxes.

## Test plan
- Single read: M1 reads 0x0000_1000, ready_in at 2nd BUSY cycle with read_value_in=0xDEADBEEF → M1 gets ready+0xDEADBEEF once; M0/M2 ready stay 0.
- Contention: M0, M1 and M2 request at the same cycle and hold → grant order 0,1,2. After M0 re-requests, M0 is served after M2.
- Write passthrough: M2 writes 0x1234_5678, mask 4'b0011 → bus shows write_out=1, the same value and mask; read_out=0.
- Timeout: TIMEOUT_CYCLES=4, slave never ready → in the 4th BUSY cycle the granted master sees ready=1, fault=1; busy_out falls next cycle.
- Abort/reset: M0 drops its request in BUSY → IDLE next cycle with no ready. reset_n low mid-BUSY → read_out/write_out are 0 immediately and rr_ptr=0 after release.
- ce_i held low 3 cycles in BUSY → counter and state frozen; ready_in while ce_i is low is still routed, and the state advances at the next ce_i edge.

Source files
------------

// File: rtl/mem_bus_scheduler_pkg.sv
// Shared types and constants for the round-robin memory bus scheduler.
package mem_bus_sched_pkg;

   localparam int MAX_MASTERS = 8;
   localparam int GRANT_W     = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Watchdog counter width; a disabled watchdog (0) still gets one bit.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_bus_scheduler_if.sv
// Master-side request/response bundle plus the shared memory bus.
interface mem_bus_sched_if #(
   parameter int NUM_MASTERS = 3
);
   logic [NUM_MASTERS-1:0][31:0] m_address_in;
   logic [NUM_MASTERS-1:0]       m_read_in;
   logic [NUM_MASTERS-1:0]       m_write_in;
   logic [NUM_MASTERS-1:0][3:0]  m_write_mask_in;
   logic [NUM_MASTERS-1:0][31:0] m_write_value_in;
   logic [NUM_MASTERS-1:0][31:0] m_read_value_out;
   logic [NUM_MASTERS-1:0]       m_ready_out;
   logic [NUM_MASTERS-1:0]       m_fault_out;

   logic [31:0] address_out;
   logic        read_out;
   logic        write_out;
   logic [3:0]  write_mask_out;
   logic [31:0] write_value_out;
   logic [31:0] read_value_in;
   logic        ready_in;
   logic        fault_in;

   // The scheduler is the slave of the masters' requests.
   modport slave (
      input  m_address_in, m_read_in, m_write_in, m_write_mask_in, m_write_value_in,
      input  read_value_in, ready_in, fault_in,
      output m_read_value_out, m_ready_out, m_fault_out,
      output address_out, read_out, write_out, write_mask_out, write_value_out
   );

   modport master (
      output m_address_in, m_read_in, m_write_in, m_write_mask_in, m_write_value_in,
      output read_value_in, ready_in, fault_in,
      input  m_read_value_out, m_ready_out, m_fault_out,
      input  address_out, read_out, write_out, write_mask_out, write_value_out
   );

endinterface

// File: rtl/mem_bus_scheduler_picker.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_priority_picker
   import mem_bus_sched_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [GRANT_W-1:0] ptr_i,
   output logic [NUM_REQ-1:0] grant_oh_o,
   output logic [GRANT_W-1:0] grant_idx_o,
   output logic               valid_o
);

   logic [NUM_REQ-1:0] at_or_after;
   logic [NUM_REQ-1:0] cand;

   always_comb begin
      at_or_after = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         at_or_after[i] = (GRANT_W'(i) >= ptr_i);
      end
      // Nothing at/after the pointer means the search wraps to index 0.
      cand = (|(req_i & at_or_after)) ? (req_i & at_or_after) : req_i;

      grant_idx_o = '0;
      grant_oh_o  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            grant_idx_o = GRANT_W'(i);
            grant_oh_o  = NUM_REQ'(1) << i;
         end
      end
      valid_o = |req_i;
   end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Round-robin owner of the shared memory bus with a watchdog that turns a hung slave into a fault.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | bus released (all common outputs 0), picking the next master
//   ST_BUSY | bus driven from the granted master until ready/abort/timeout
module mem_bus_scheduler
   import mem_bus_sched_pkg::*;
#(
   parameter int NUM_MASTERS    = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               ce_i,
   mem_bus_sched_if.slave     bus,
   output logic [GRANT_W-1:0] grant_idx_out,
   output logic               busy_out
);

   localparam int                 CNT_W    = cnt_width(TIMEOUT_CYCLES);
   localparam bit                 WDOG_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0]   CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
   localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(NUM_MASTERS - 1);

   if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_cfg
      $error("mem_bus_scheduler: NUM_MASTERS out of range");
   end

   state_e                 state_q, state_d;
   logic [GRANT_W-1:0]     grant_q, grant_d;
   logic [NUM_MASTERS-1:0] grant_oh_q, grant_oh_d;
   logic [GRANT_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] pick_oh;
   logic [GRANT_W-1:0]     pick_idx;
   logic                   pick_valid;
   logic                   busy;
   logic                   req_g;
   logic                   timeout_fire;

   logic [31:0]            g_address;
   logic                   g_read;
   logic                   g_write;
   logic [3:0]             g_mask;
   logic [31:0]            g_value;

   assign req  = bus.m_read_in | bus.m_write_in;
   assign busy = (state_q == ST_BUSY);

   rr_priority_picker #(
      .NUM_REQ (NUM_MASTERS)
   ) u_picker (
      .req_i       (req),
      .ptr_i       (rr_ptr_q),
      .grant_oh_o  (pick_oh),
      .grant_idx_o (pick_idx),
      .valid_o     (pick_valid)
   );

   always_comb begin
      g_address = '0;
      g_read    = 1'b0;
      g_write   = 1'b0;
      g_mask    = '0;
      g_value   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_oh_q[i]) begin
            g_address = bus.m_address_in[i];
            g_read    = bus.m_read_in[i];
            g_write   = bus.m_write_in[i];
            g_mask    = bus.m_write_mask_in[i];
            g_value   = bus.m_write_value_in[i];
         end
      end
   end

   assign req_g        = |(req & grant_oh_q);
   assign timeout_fire = WDOG_EN && busy && req_g && !bus.ready_in && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         grant_oh_q <= '0;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_oh_q <= grant_oh_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_oh_d = grant_oh_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = cnt_q;
      if (ce_i) begin
         unique case (state_q)
            ST_IDLE: begin
               if (pick_valid) begin
                  state_d    = ST_BUSY;
                  grant_d    = pick_idx;
                  grant_oh_d = pick_oh;
                  cnt_d      = '0;
               end
            end
            ST_BUSY: begin
               // Abort leaves the pointer alone so the same master is not skipped.
               if (!req_g) begin
                  state_d = ST_IDLE;
               end else if (bus.ready_in || timeout_fire) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.address_out      = '0;
      bus.read_out         = 1'b0;
      bus.write_out        = 1'b0;
      bus.write_mask_out   = '0;
      bus.write_value_out  = '0;
      bus.m_read_value_out = '0;
      bus.m_ready_out      = '0;
      bus.m_fault_out      = '0;
      if (busy) begin
         bus.address_out     = g_address;
         bus.read_out        = g_read  & ~timeout_fire;
         bus.write_out       = g_write & ~timeout_fire;
         bus.write_mask_out  = g_mask;
         bus.write_value_out = g_value;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_oh_q[i]) begin
               bus.m_read_value_out[i] = bus.read_value_in;
            end
         end
         if (req_g) begin
            bus.m_ready_out = grant_oh_q & {NUM_MASTERS{bus.ready_in | timeout_fire}};
            bus.m_fault_out = grant_oh_q & {NUM_MASTERS{bus.fault_in | timeout_fire}};
         end
      end
   end

   assign grant_idx_out = grant_q;
   assign busy_out      = busy;

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Directed bench for mem_bus_scheduler: 3 masters, 4-cycle watchdog.
module tb_mem_bus_scheduler;

   logic       clk;
   logic       reset_n;
   logic       ce_i;
   logic [2:0] grant_idx;
   logic       busy;

   int checks_n = 0;
   int errors_n = 0;

   mem_bus_sched_if #(.NUM_MASTERS(3)) bus_if ();

   mem_bus_scheduler #(
      .NUM_MASTERS    (3),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ce_i          (ce_i),
      .bus           (bus_if.slave),
      .grant_idx_out (grant_idx),
      .busy_out      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_n++;
      if (got !== exp) begin
         errors_n++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 2ns after the active edge; outputs are checked before the next edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset_n                  = 1'b0;
      ce_i                     = 1'b1;
      bus_if.m_address_in      = '0;
      bus_if.m_read_in         = '0;
      bus_if.m_write_in        = '0;
      bus_if.m_write_mask_in   = '0;
      bus_if.m_write_value_in  = '0;
      bus_if.read_value_in     = '0;
      bus_if.ready_in          = 1'b0;
      bus_if.fault_in          = 1'b0;

      step();
      step();
      #1;
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_grant",  32'(grant_idx), 32'd0);
      chk("rst_read",   32'(bus_if.read_out), 32'd0);
      chk("rst_addr",   bus_if.address_out, 32'd0);
      chk("rst_ready",  32'(bus_if.m_ready_out), 32'd0);
      reset_n = 1'b1;

      // single read by M1, slave answers in the 2nd BUSY cycle
      step();
      bus_if.m_read_in[1]    = 1'b1;
      bus_if.m_address_in[1] = 32'h0000_1000;
      step();
      chk("rd_busy",    32'(busy), 32'd1);
      chk("rd_grant",   32'(grant_idx), 32'd1);
      chk("rd_addr",    bus_if.address_out, 32'h0000_1000);
      chk("rd_read",    32'(bus_if.read_out), 32'd1);
      chk("rd_noready", 32'(bus_if.m_ready_out), 32'd0);
      step();
      bus_if.ready_in      = 1'b1;
      bus_if.read_value_in = 32'hDEAD_BEEF;
      #1;
      chk("rd_ready",   32'(bus_if.m_ready_out), 32'b010);
      chk("rd_val_m1",  bus_if.m_read_value_out[1], 32'hDEAD_BEEF);
      chk("rd_val_m0",  bus_if.m_read_value_out[0], 32'd0);
      step();
      chk("rd_idle",    32'(busy), 32'd0);
      chk("rd_once",    32'(bus_if.m_ready_out), 32'd0);
      chk("rd_release", 32'(bus_if.read_out), 32'd0);
      bus_if.m_read_in[1] = 1'b0;
      bus_if.ready_in     = 1'b0;

      // write passthrough by M2 (pointer now 2)
      step();
      bus_if.m_write_in[2]       = 1'b1;
      bus_if.m_address_in[2]     = 32'h0000_2000;
      bus_if.m_write_value_in[2] = 32'h1234_5678;
      bus_if.m_write_mask_in[2]  = 4'b0011;
      step();
      chk("wr_grant",   32'(grant_idx), 32'd2);
      chk("wr_write",   32'(bus_if.write_out), 32'd1);
      chk("wr_read",    32'(bus_if.read_out), 32'd0);
      chk("wr_value",   bus_if.write_value_out, 32'h1234_5678);
      chk("wr_mask",    32'(bus_if.write_mask_out), 32'h3);
      chk("wr_addr",    bus_if.address_out, 32'h0000_2000);
      bus_if.ready_in = 1'b1;
      #1;
      chk("wr_ready",   32'(bus_if.m_ready_out), 32'b100);
      step();
      bus_if.m_write_in[2] = 1'b0;
      bus_if.ready_in      = 1'b0;

      // contention: all three request together, then M0 comes back
      step();
      bus_if.m_read_in       = 3'b111;
      bus_if.m_address_in[0] = 32'h100;
      bus_if.m_address_in[1] = 32'h200;
      bus_if.m_address_in[2] = 32'h300;
      step();
      chk("rr_first",   32'(grant_idx), 32'd0);
      chk("rr_addr0",   bus_if.address_out, 32'h100);
      bus_if.ready_in = 1'b1;
      step();
      chk("rr_gap",     32'(busy), 32'd0);
      bus_if.m_read_in[0] = 1'b0;
      bus_if.ready_in     = 1'b0;
      step();
      chk("rr_second",  32'(grant_idx), 32'd1);
      chk("rr_addr1",   bus_if.address_out, 32'h200);
      bus_if.ready_in     = 1'b1;
      bus_if.m_read_in[0] = 1'b1;
      step();
      bus_if.m_read_in[1] = 1'b0;
      bus_if.ready_in     = 1'b0;
      step();
      chk("rr_third",   32'(grant_idx), 32'd2);
      bus_if.ready_in = 1'b1;
      step();
      bus_if.m_read_in[2] = 1'b0;
      bus_if.ready_in     = 1'b0;
      step();
      chk("rr_m0_again", 32'(grant_idx), 32'd0);
      chk("rr_m0_busy",  32'(busy), 32'd1);
      bus_if.ready_in = 1'b1;
      step();
      bus_if.m_read_in[0] = 1'b0;
      bus_if.ready_in     = 1'b0;

      // watchdog: slave never answers (pointer now 1)
      step();
      bus_if.m_read_in[1]    = 1'b1;
      bus_if.m_address_in[1] = 32'h0000_4000;
      step();
      chk("to_grant",   32'(grant_idx), 32'd1);
      chk("to_c1_rdy",  32'(bus_if.m_ready_out), 32'd0);
      step();
      step();
      chk("to_c3_rdy",  32'(bus_if.m_ready_out), 32'd0);
      chk("to_c3_flt",  32'(bus_if.m_fault_out), 32'd0);
      chk("to_c3_read", 32'(bus_if.read_out), 32'd1);
      step();
      chk("to_c4_rdy",  32'(bus_if.m_ready_out), 32'b010);
      chk("to_c4_flt",  32'(bus_if.m_fault_out), 32'b010);
      chk("to_c4_read", 32'(bus_if.read_out), 32'd0);
      chk("to_c4_busy", 32'(busy), 32'd1);
      step();
      chk("to_idle",    32'(busy), 32'd0);
      bus_if.m_read_in[1] = 1'b0;

      // abort: M0 drops its request mid-transaction (pointer 2, wraps to 0)
      step();
      bus_if.m_read_in[0] = 1'b1;
      step();
      chk("ab_grant",   32'(grant_idx), 32'd0);
      bus_if.m_read_in[0] = 1'b0;
      bus_if.ready_in     = 1'b1;
      #1;
      chk("ab_noready", 32'(bus_if.m_ready_out), 32'd0);
      step();
      chk("ab_idle",    32'(busy), 32'd0);
      bus_if.ready_in = 1'b0;

      // reset mid-BUSY; pointer was 2, so M0 vs M2 afterwards reveals it
      step();
      bus_if.m_read_in[1] = 1'b1;
      step();
      chk("rs_grant",   32'(grant_idx), 32'd1);
      chk("rs_read",    32'(bus_if.read_out), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rs_read0",   32'(bus_if.read_out), 32'd0);
      chk("rs_busy0",   32'(busy), 32'd0);
      chk("rs_rdy0",    32'(bus_if.m_ready_out), 32'd0);
      bus_if.m_read_in[1] = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      bus_if.m_read_in[0] = 1'b1;
      bus_if.m_read_in[2] = 1'b1;
      step();
      chk("rs_ptr0",    32'(grant_idx), 32'd0);
      bus_if.ready_in = 1'b1;
      step();
      bus_if.m_read_in[0] = 1'b0;
      bus_if.ready_in     = 1'b0;

      // clock enable low for three cycles while M2 is granted
      step();
      chk("ce_grant",   32'(grant_idx), 32'd2);
      ce_i = 1'b0;
      step();
      step();
      step();
      chk("ce_busy",    32'(busy), 32'd1);
      chk("ce_grant_h", 32'(grant_idx), 32'd2);
      chk("ce_nofault", 32'(bus_if.m_fault_out), 32'd0);
      bus_if.ready_in = 1'b1;
      #1;
      chk("ce_route",   32'(bus_if.m_ready_out), 32'b100);
      step();
      chk("ce_hold",    32'(busy), 32'd1);
      ce_i = 1'b1;
      step();
      chk("ce_advance", 32'(busy), 32'd0);
      bus_if.m_read_in[2] = 1'b0;
      bus_if.ready_in     = 1'b0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
      $finish;
   end

endmodule
